// File: rtl/fir_pkg.sv
// Shared widths and the block record passed from the serial-to-parallel
// assembler to the 4-parallel FIR.
package fir_pkg;

   localparam int unsigned DATA_W = 16;
   localparam int unsigned LANES  = 4;

   typedef struct packed {
      logic [LANES-1:0][DATA_W-1:0] data;
      logic                         last;
      logic [1:0]                   pad;
   } fir_blk_t;

endpackage

// File: rtl/fir_blk_fifo.sv
// Two-entry block FIFO; head is presented combinationally from storage.
module fir_blk_fifo
   import fir_pkg::*;
#(
   parameter type T = fir_blk_t
) (
   input  logic clk,
   input  logic rst,
   input  logic push,
   input  T     wdata,
   input  logic pop,
   output T     rdata,
   output logic empty,
   output logic full
);

   T           mem [2];
   logic       wr_ptr;
   logic       rd_ptr;
   logic [1:0] cnt;
   logic       do_push;
   logic       do_pop;

   assign empty   = (cnt == 2'd0);
   assign full    = (cnt == 2'd2);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!rst) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         cnt    <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= ~wr_ptr;
         end
         if (do_pop)
            rd_ptr <= ~rd_ptr;
         cnt <= cnt + {1'b0, do_push} - {1'b0, do_pop};
      end
   end

endmodule

// File: rtl/fir_s2p4.sv
// Serial-to-4-parallel block assembler feeding a 4-parallel FIR; short final
// blocks are zero-padded and flagged with out_last/out_pad.
module fir_s2p4
   import fir_pkg::*;
#(
   parameter int unsigned DATA_W = fir_pkg::DATA_W,
   parameter int unsigned LANES  = fir_pkg::LANES
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data0,
   output logic [DATA_W-1:0] out_data1,
   output logic [DATA_W-1:0] out_data2,
   output logic [DATA_W-1:0] out_data3,
   output logic              out_last,
   output logic [1:0]        out_pad,
   output logic [15:0]       blk_cnt
);

   logic [1:0]        lane_idx;
   logic [DATA_W-1:0] lanes [LANES];
   logic [15:0]       blk_cnt_q;
   logic              accept;
   logic              complete;
   logic              pop;
   logic              empty;
   logic              full;
   fir_blk_t          blk;
   fir_blk_t          head;

   // in_ready depends only on reset and FIFO occupancy, never on out_ready.
   assign in_ready = rst & ~full;
   assign accept   = in_valid & in_ready;
   assign complete = accept & (in_last | (lane_idx == 2'd3));
   assign out_valid = ~empty;
   assign pop      = out_valid & out_ready;

   // Lanes below lane_idx come from storage, the current one straight from
   // in_data, and any lanes beyond it are the zero padding.
   always_comb begin
      blk = '0;
      for (int unsigned i = 0; i < LANES; i++) begin
         if (i < 32'(lane_idx))
            blk.data[i] = lanes[i];
         else if (i == 32'(lane_idx))
            blk.data[i] = in_data;
      end
      blk.last = in_last;
      blk.pad  = 2'd3 - lane_idx;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         lane_idx <= '0;
         for (int unsigned i = 0; i < LANES; i++)
            lanes[i] <= '0;
         blk_cnt_q <= '0;
      end else begin
         if (accept) begin
            lanes[lane_idx] <= in_data;
            lane_idx        <= complete ? 2'd0 : lane_idx + 2'd1;
         end
         if (pop)
            blk_cnt_q <= blk_cnt_q + 16'd1;
      end
   end

   fir_blk_fifo #(
      .T (fir_blk_t)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (complete),
      .wdata (blk),
      .pop   (pop),
      .rdata (head),
      .empty (empty),
      .full  (full)
   );

   assign out_data0 = out_valid ? head.data[0] : '0;
   assign out_data1 = out_valid ? head.data[1] : '0;
   assign out_data2 = out_valid ? head.data[2] : '0;
   assign out_data3 = out_valid ? head.data[3] : '0;
   assign out_last  = out_valid ? head.last    : 1'b0;
   assign out_pad   = out_valid ? head.pad     : 2'd0;
   assign blk_cnt   = blk_cnt_q;

endmodule

// File: tb/tb_fir_s2p4.sv
// Directed bench for fir_s2p4: block assembly, padding, backpressure,
// concurrent push/pop, mid-block reset and blk_cnt wrap.
`timescale 1ns/1ps
module tb_fir_s2p4;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic        in_last;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data0, out_data1, out_data2, out_data3;
   logic        out_last;
   logic [1:0]  out_pad;
   logic [15:0] blk_cnt;

   int checks = 0;
   int errors = 0;
   logic [66:0] q [$];

   always #5 clk = ~clk;

   fir_s2p4 #(.DATA_W(16), .LANES(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data0 (out_data0),
      .out_data1 (out_data1),
      .out_data2 (out_data2),
      .out_data3 (out_data3),
      .out_last  (out_last),
      .out_pad   (out_pad),
      .blk_cnt   (blk_cnt)
   );

   // Record every block that will be popped at the coming rising edge.
   always @(negedge clk)
      if (out_valid && out_ready)
         q.push_back({out_data0, out_data1, out_data2, out_data3, out_last, out_pad});

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   function automatic logic [66:0] mk(input int a, input int b, input int c, input int d,
                                      input bit last, input int pad);
      return {16'(a), 16'(b), 16'(c), 16'(d), last, 2'(pad)};
   endfunction

   task automatic expect_blk(input string tag, input logic [66:0] exp);
      int n = 0;
      while (q.size() == 0 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (q.size() == 0)
         check({tag, "_timeout"}, 0, 1);
      else
         check(tag, q.pop_front(), exp);
   endtask

   task automatic send(input int v, input bit last);
      bit acc = 1'b0;
      int n = 0;
      in_valid = 1'b1;
      in_data  = 16'(v);
      in_last  = last;
      while (!acc && n < 50) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk); #1;
         n++;
      end
      if (!acc) check("send_timeout", 0, 1);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b0;
      in_valid = 1'b0;
      in_last = 1'b0;
      @(negedge clk);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      @(posedge clk); #1;
      @(negedge clk);
      check("rst_blk_cnt", blk_cnt, 0);
      check("rst_head", {out_data0, out_data1, out_data2, out_data3, out_last, out_pad}, 0);
      @(posedge clk); #1;
      rst = 1'b1;
      q.delete();
   endtask

   initial begin
      rst = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;

      // Back-to-back 1..8
      do_reset();
      for (int i = 1; i <= 3; i++) send(i, 0);
      check("t1_no_valid_early", out_valid, 0);
      send(4, 0);
      check("t1_latency_blk0", out_valid, 1);
      for (int i = 5; i <= 8; i++) send(i, 0);
      check("t1_latency_blk1", out_valid, 1);
      repeat (3) @(posedge clk);
      #1;
      expect_blk("t1_blk0", mk(1, 2, 3, 4, 0, 0));
      expect_blk("t1_blk1", mk(5, 6, 7, 8, 0, 0));
      check("t1_blk_cnt", blk_cnt, 2);
      check("t1_drained", out_valid, 0);

      // Early in_last pads, then assembly restarts at lane 0
      do_reset();
      for (int i = 1; i <= 5; i++) send(i, 0);
      send(6, 1);
      for (int i = 7; i <= 10; i++) send(i, 0);
      for (int i = 11; i <= 13; i++) send(i, 0);
      send(14, 1);
      send(15, 1);
      expect_blk("t2_blk0", mk(1, 2, 3, 4, 0, 0));
      expect_blk("t2_pad2", mk(5, 6, 0, 0, 1, 2));
      expect_blk("t2_lane0", mk(7, 8, 9, 10, 0, 0));
      expect_blk("t2_last_lane3", mk(11, 12, 13, 14, 1, 0));
      expect_blk("t2_pad3", mk(15, 0, 0, 0, 1, 3));

      // Backpressure: FIFO fills after 8 samples
      do_reset();
      out_ready = 1'b0;
      for (int i = 1; i <= 8; i++) send(i, 0);
      check("t3_ready_low", in_ready, 0);
      in_valid = 1'b1; in_data = 16'd9; in_last = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("t3_ready_held_low", in_ready, 0);
      check("t3_head_hold", {out_data0, out_data1, out_data2, out_data3}, {16'd1, 16'd2, 16'd3, 16'd4});
      check("t3_no_pop", blk_cnt, 0);
      out_ready = 1'b1;
      @(negedge clk);
      check("t3_ready_before_pop", in_ready, 0);
      @(posedge clk); #1;
      @(negedge clk);
      check("t3_ready_after_pop", in_ready, 1);
      @(posedge clk); #1;
      for (int i = 10; i <= 12; i++) send(i, 0);
      expect_blk("t3_blk0", mk(1, 2, 3, 4, 0, 0));
      expect_blk("t3_blk1", mk(5, 6, 7, 8, 0, 0));
      expect_blk("t3_blk2", mk(9, 10, 11, 12, 0, 0));

      // Push and pop in the same cycle with one block queued
      do_reset();
      out_ready = 1'b0;
      for (int i = 1; i <= 7; i++) send(i, 0);
      out_ready = 1'b1;
      send(8, 0);
      out_ready = 1'b0;
      check("t4_count_one_valid", out_valid, 1);
      check("t4_count_one_ready", in_ready, 1);
      check("t4_head", out_data0, 5);
      out_ready = 1'b1;
      expect_blk("t4_blk0", mk(1, 2, 3, 4, 0, 0));
      expect_blk("t4_blk1", mk(5, 6, 7, 8, 0, 0));

      // Reset pulse mid-block discards the partial block
      do_reset();
      out_ready = 1'b1;
      send(1, 0);
      send(2, 0);
      rst = 1'b0;
      @(negedge clk);
      check("t5_rst_ready", in_ready, 0);
      @(posedge clk); #1;
      rst = 1'b1;
      for (int i = 10; i <= 13; i++) send(i, 0);
      repeat (3) @(posedge clk);
      #1;
      check("t5_one_block", q.size(), 1);
      expect_blk("t5_blk", mk(10, 11, 12, 13, 0, 0));
      check("t5_blk_cnt", blk_cnt, 1);

      // blk_cnt wrap
      do_reset();
      out_ready = 1'b0;
      for (int i = 1; i <= 4; i++) send(i, 0);
      force dut.blk_cnt_q = 16'hFFFF;
      @(negedge clk);
      release dut.blk_cnt_q;
      @(posedge clk); #1;
      check("t6_preload", blk_cnt, 16'hFFFF);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("t6_wrap", blk_cnt, 16'h0000);
      expect_blk("t6_blk", mk(1, 2, 3, 4, 0, 0));
      check("t6_queue_empty", q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
